// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader that fills the mips instruction memory and holds the core in reset.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the last word.
module imem_loader #(
  parameter int ADDR_W    = 5,
  parameter int MEM_WORDS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RECV  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_CHECK = 3'd5,
    S_ERROR = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RECV  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;
`endif

  localparam logic [ADDR_W:0] LP_MAX_LEN = (ADDR_W+1)'(MEM_WORDS);
  localparam logic [ADDR_W:0] LP_ONE     = (ADDR_W+1)'(1);

  state_t            r_state;
  logic [ADDR_W:0]   r_eff_len;
  logic [ADDR_W-1:0] r_word_addr;
  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_shift;
  logic              r_byte_ready;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;
  logic              r_cpu_rst_n;
  logic              r_busy;
  logic              r_done;

  logic [ADDR_W:0]   w_clamp_len;
  logic              w_xfer;
  logic              w_last_word;
  logic              w_can_start;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
  logic              r_err;

  function automatic logic [7:0] f_xor_word(input logic [31:0] word);
    f_xor_word = word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
  endfunction

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign w_clamp_len = (len > LP_MAX_LEN) ? LP_MAX_LEN : len;
  assign w_xfer      = byte_valid & r_byte_ready;
  assign w_last_word = ({1'b0, r_word_addr} == (r_eff_len - LP_ONE));

  // A new load may begin only from a resting state.
  always_comb begin
    w_can_start = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: w_can_start = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_ERROR:        w_can_start = 1'b1;
`endif
      default:        w_can_start = 1'b0;
    endcase
  end

  // Loader FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_eff_len    <= {(ADDR_W+1){1'b0}};
      r_word_addr  <= {ADDR_W{1'b0}};
      r_byte_cnt   <= 2'd0;
      r_shift      <= 24'd0;
      r_byte_ready <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= {ADDR_W{1'b0}};
      r_imem_wdata <= 32'd0;
      r_cpu_rst_n  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum       <= 8'd0;
      r_err        <= 1'b0;
`endif
    end else begin
      r_imem_we <= 1'b0;
      if (start && w_can_start) begin
        // ARM gives the registered eff_len a cycle before the zero-length decision.
        r_state      <= S_ARM;
        r_eff_len    <= w_clamp_len;
        r_word_addr  <= {ADDR_W{1'b0}};
        r_byte_cnt   <= 2'd0;
        r_shift      <= 24'd0;
        r_byte_ready <= 1'b0;
        r_busy       <= 1'b1;
        r_done       <= 1'b0;
        r_cpu_rst_n  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        r_csum       <= 8'd0;
        r_err        <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_ARM: begin
            if (r_eff_len == {(ADDR_W+1){1'b0}}) begin
              r_state     <= S_DONE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_cpu_rst_n <= 1'b1;
            end else begin
              r_state      <= S_RECV;
              r_byte_ready <= 1'b1;
            end
          end
          S_RECV: begin
            if (w_xfer) begin
              r_shift    <= {r_shift[15:0], byte_data};
              r_byte_cnt <= r_byte_cnt + 2'd1;
              if (r_byte_cnt == 2'd3) begin
                r_state      <= S_WRITE;
                r_byte_ready <= 1'b0;
                r_imem_we    <= 1'b1;
                r_imem_addr  <= r_word_addr;
                r_imem_wdata <= {r_shift, byte_data};
              end
            end
          end
          S_WRITE: begin
            r_word_addr <= r_word_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            r_byte_cnt  <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
            r_csum      <= r_csum ^ f_xor_word(r_imem_wdata);
            if (w_last_word) begin
              r_state      <= S_CHECK;
              r_byte_ready <= 1'b1;
            end else begin
              r_state      <= S_RECV;
              r_byte_ready <= 1'b1;
            end
`else
            if (w_last_word) begin
              r_state     <= S_DONE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_cpu_rst_n <= 1'b1;
            end else begin
              r_state      <= S_RECV;
              r_byte_ready <= 1'b1;
            end
`endif
          end
`ifdef LOADER_CHECKSUM_EN
          S_CHECK: begin
            if (w_xfer) begin
              r_byte_ready <= 1'b0;
              r_busy       <= 1'b0;
              if (byte_data == r_csum) begin
                r_state     <= S_DONE;
                r_done      <= 1'b1;
                r_cpu_rst_n <= 1'b1;
              end else begin
                r_state <= S_ERROR;
                r_err   <= 1'b1;
              end
            end
          end
`endif
          default: r_state <= r_state;
        endcase
      end
    end
  end

  assign byte_ready = r_byte_ready;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign cpu_rst_n  = r_cpu_rst_n;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
